jb_intr_agg: RTL and testbench



---
 rtl/jb_intr_agg.sv | 110 +++++++++++
 tb/tb_jb_intr_agg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_intr_agg.sv
// Interrupt aggregator: synchronizes raw sources, latches rising edges into sticky
// pending bits, and drives a masked master interrupt with a guaranteed low gap.
module jb_intr_agg #(
  parameter int N_SRC       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] pl_irq_mask,
  input  logic [N_SRC-1:0] pl_irq_clear,
  input  logic             pl_master_irq_mask,
  output logic [N_SRC-1:0] pl_irq,
  output logic [N_SRC-1:0] src_sync,
  output logic             pl_master_irq,
  output logic [15:0]      irq_count
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);
  localparam logic [7:0] HOLD_INIT = 8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam bit NO_HOLD = (HOLDOFF == 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] rise;
  logic [WARM_W-1:0] warm;
  logic             armed;
  logic             pending_any;
  state_t           state, state_nx;
  logic [7:0]       hold_cnt, hold_cnt_nx;
  logic             count_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= src_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign src_sync = sync_q[SYNC_STAGES-1];

  // Edges are ignored until the chain has refilled after reset, so a source that
  // was already high at reset release is not mistaken for a fresh rising edge.
  assign armed = (warm == WARM_DONE);
  assign rise  = armed ? (src_sync & ~src_d) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm   <= '0;
      src_d  <= '0;
      pl_irq <= '0;
    end else begin
      if (!armed) warm <= warm + 1'b1;
      src_d  <= src_sync;
      pl_irq <= rise | (pl_irq & ~pl_irq_clear);
    end
  end

  assign pending_any = (|(pl_irq & ~pl_irq_mask)) & ~pl_master_irq_mask;

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    count_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending_any) begin
          state_nx  = ST_ASSERT;
          count_inc = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (!pending_any) begin
          state_nx    = NO_HOLD ? ST_IDLE : ST_HOLD;
          hold_cnt_nx = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == 8'd0) state_nx = ST_IDLE;
        else                  hold_cnt_nx = hold_cnt - 8'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      irq_count <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      if (count_inc && (irq_count != 16'hFFFF)) irq_count <= irq_count + 16'd1;
    end
  end

  assign pl_master_irq = (state == ST_ASSERT);

endmodule

// File: tb/tb_jb_intr_agg.sv
// Bench for jb_intr_agg: directed scenarios plus random traffic against a
// sample-history reference model; a second HOLDOFF=0 instance exercises count saturation.
module tb_jb_intr_agg;
  localparam int S = 2;
  localparam int H = 8;

  int checks = 0;
  int failures = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic clk2 = 1'b0;
  logic rst2 = 1'b0;
  always #2 clk2 = ~clk2;

  logic [31:0] src_in = '0, mask = '0, clr = '0;
  logic        mmask = 1'b0;
  logic [31:0] pl_irq, src_sync;
  logic        master;
  logic [15:0] irq_count;

  logic [31:0] src2 = '0, zero32 = '0;
  logic        mmask2 = 1'b0;
  logic [31:0] irq2, sync2;
  logic        master2;
  logic [15:0] count2;
  bit          sat_done = 1'b0;

  jb_intr_agg #(.N_SRC(32), .SYNC_STAGES(S), .HOLDOFF(H)) u_dut (
    .clk(clk), .rst(rst), .src_in(src_in), .pl_irq_mask(mask), .pl_irq_clear(clr),
    .pl_master_irq_mask(mmask), .pl_irq(pl_irq), .src_sync(src_sync),
    .pl_master_irq(master), .irq_count(irq_count));

  jb_intr_agg #(.N_SRC(32), .SYNC_STAGES(S), .HOLDOFF(0)) u_sat (
    .clk(clk2), .rst(rst2), .src_in(src2), .pl_irq_mask(zero32), .pl_irq_clear(zero32),
    .pl_master_irq_mask(mmask2), .pl_irq(irq2), .src_sync(sync2),
    .pl_master_irq(master2), .irq_count(count2));

  // reference model: history of samples taken since reset plus master gap rule
  logic [31:0] samp_q[$];
  logic [31:0] m_pend, m_sync;
  bit          m_master;
  int          m_low_run, m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    m_pend = '0; m_sync = '0; m_master = 0; m_low_run = H + 1; m_count = 0;
  endtask

  task automatic model_edge();
    logic [31:0] rise;
    bit pany, nm;
    rise = '0;
    if (samp_q.size() == S + 1) rise = samp_q[1] & ~samp_q[0];
    pany = (|(m_pend & ~mask)) && !mmask;
    nm = pany && (m_master || m_low_run >= H + 1);
    if (nm && !m_master && m_count < 65535) m_count++;
    if (!nm) m_low_run = m_master ? 1 : ((m_low_run < 1000) ? m_low_run + 1 : m_low_run);
    m_master = nm;
    m_pend = rise | (m_pend & ~clr);
    samp_q.push_back(src_in);
    if (samp_q.size() > S + 1) void'(samp_q.pop_front());
    m_sync = (samp_q.size() >= S) ? samp_q[samp_q.size() - S] : '0;
  endtask

  // driver: one clock edge, then compare every output with the model
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_irq"}, pl_irq, m_pend);
    chk({tag, "_sync"}, src_sync, m_sync);
    chk({tag, "_master"}, {31'b0, master}, {31'b0, m_master});
    chk({tag, "_count"}, {16'b0, irq_count}, m_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_irq", pl_irq, 0);
    chk("rst_master", {31'b0, master}, 0);
    chk("rst_count", {16'b0, irq_count}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int low_cycles, cnt_before;
    #2;
    // source already high across reset release must not create an edge
    src_in = 32'h1;
    do_reset();
    repeat (10) step("held");
    chk("held_no_edge", pl_irq, 0);
    chk("held_master_low", {31'b0, master}, 0);

    // drop and re-raise bit 0: sync after edge 1, pending edge 2, master edge 3
    src_in = 0;
    repeat (4) step("drop");
    src_in = 32'h1;
    step("lat0");
    step("lat1");
    chk("lat_sync", src_sync, 32'h1);
    step("lat2");
    chk("lat_pend", pl_irq, 32'h1);
    chk("lat_master_early", {31'b0, master}, 0);
    step("lat3");
    chk("lat_master", {31'b0, master}, 1);
    chk("lat_count", {16'b0, irq_count}, 1);
    clr = 32'h1; step("clr0"); clr = 0;
    chk("clr0_pend", pl_irq, 0);
    step("clr0b");
    chk("clr0_master", {31'b0, master}, 0);
    src_in = 0;
    repeat (10) step("gap");

    // per-bit mask gates the master but leaves pending visible
    mask = 32'h20; src_in = 32'h20;
    repeat (5) step("mask");
    chk("mask_pend", pl_irq, 32'h20);
    chk("mask_master", {31'b0, master}, 0);
    mask = 0; step("unmask");
    chk("unmask_master", {31'b0, master}, 1);
    clr = 32'h20; step("clr5"); clr = 0;
    chk("clr5_pend", pl_irq, 0);
    step("clr5b");
    chk("clr5_master", {31'b0, master}, 0);
    src_in = 0;
    repeat (10) step("gap");

    // clear and rise on bit 3 in the same cycle: set wins
    src_in = 32'h8;
    repeat (5) step("b3");
    src_in = 0;
    repeat (3) step("b3low");
    src_in = 32'h8;
    step("b3r0"); step("b3r1");
    clr = 32'h8; step("b3same"); clr = 0;
    chk("setwins_pend", pl_irq, 32'h8);
    chk("setwins_master", {31'b0, master}, 1);
    step("b3hold");
    chk("setwins_master2", {31'b0, master}, 1);

    // holdoff: new edge during holdoff waits out the full low gap
    cnt_before = m_count;
    clr = 32'h8; step("ho_clr"); clr = 0;
    step("ho_low");
    src_in = 32'h88;
    low_cycles = 1;
    for (int i = 0; i < 40 && !master; i++) begin
      step("ho_wait");
      if (!master) low_cycles++;
    end
    chk("holdoff_low_cycles", low_cycles, H + 1);
    chk("holdoff_master", {31'b0, master}, 1);
    chk("holdoff_count", {16'b0, irq_count}, cnt_before + 1);
    clr = 32'h80; step("ho_clr2"); clr = 0;
    src_in = 0;
    repeat (12) step("gap");

    // master mask with all bits pending
    mmask = 1'b1;
    src_in = 32'hFFFF_FFFF;
    repeat (5) step("mm");
    chk("mmask_pend", pl_irq, 32'hFFFF_FFFF);
    chk("mmask_master", {31'b0, master}, 0);
    mmask = 1'b0; step("mm_rel");
    chk("mmask_rel_master", {31'b0, master}, 1);
    clr = 32'hFFFF_FFFF; step("mm_clr"); clr = 0;
    src_in = 0;
    repeat (12) step("gap");

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) src_in = src_in ^ (32'h1 << $urandom_range(0, 31));
      clr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      if ($urandom_range(0, 15) == 0) mask = $urandom & $urandom;
      mmask = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    clr = 0; mask = 0; mmask = 0; src_in = 0;
    repeat (12) step("gap");

    // asynchronous reset in the middle of holdoff
    src_in = 32'h4;
    repeat (5) step("pre_rst");
    clr = 32'h4; step("pre_rst_clr"); clr = 0;
    step("in_hold");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_irq", pl_irq, 0);
    chk("midrst_sync", src_sync, 0);
    chk("midrst_master", {31'b0, master}, 0);
    chk("midrst_count", {16'b0, irq_count}, 0);
    src_in = 0;
    do_reset();
    repeat (4) step("post_rst");
    src_in = 32'h2;
    repeat (4) step("post_rst_edge");
    chk("post_rst_master", {31'b0, master}, 1);
    chk("post_rst_count", {16'b0, irq_count}, 1);

    // wait for the saturation run, bounded
    for (int i = 0; i < 20000 && !sat_done; i++) #100;
    chk("sat_done", {31'b0, sat_done}, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // saturation: HOLDOFF=0 instance, master mask toggled to re-assert every 2 cycles
  initial begin
    int exp_cnt;
    #1;
    rst2 = 1'b1;
    repeat (3) @(posedge clk2);
    #1;
    chk("sat_rst_count", {16'b0, count2}, 0);
    mmask2 = 1'b1;
    rst2 = 1'b0;
    repeat (4) @(posedge clk2);
    #1;
    src2 = 32'h1;
    repeat (6) @(posedge clk2);
    #1;
    chk("sat_pend", irq2, 32'h1);
    for (int n = 1; n <= 65540; n++) begin
      mmask2 = 1'b0;
      @(posedge clk2);
      #1;
      if (n == 1000 || n == 65534 || n == 65535 || n == 65540) begin
        exp_cnt = (n > 65535) ? 65535 : n;
        chk("sat_count", {16'b0, count2}, exp_cnt);
        chk("sat_master", {31'b0, master2}, 1);
      end
      mmask2 = 1'b1;
      @(posedge clk2);
      #1;
    end
    sat_done = 1'b1;
  end
endmodule
